spi_cmd_slave_mc: RTL and testbench

- Next-generation SPI command slave for the motor controller. All logic runs in the system clock domain: SPI pins are synchronised and edge-detected, with no logic clocked by SCLK.
- Serves NUM_CH motor channels with a PWM set-point register and quadrature-count readback each, plus LED toggle, soft reset and a status/error readback.
- Sits between the external SPI master and the per-channel PWM generators and QD counters.

---
 rtl/spi_cmd_slave_mc.sv | 190 +++++++++++++++++++
 tb/tb_spi_cmd_slave_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_slave_mc.sv
// SPI mode-0 command slave for the motor controller: PWM set-points, QD count readback,
// LED, soft reset and status. Everything runs on clk; SPI pins are synchronised and edge-detected.
module spi_cmd_slave_mc #(
    parameter int NUM_CH         = 2,
    parameter int PWM_DATA_WIDTH = 16,
    parameter int QD_DATA_WIDTH  = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                spi_sclk,
    input  logic                                spi_cs_n,
    input  logic                                spi_mosi,
    output logic                                spi_miso,
    input  logic [NUM_CH*QD_DATA_WIDTH-1:0]     qd_count,
    output logic [NUM_CH*PWM_DATA_WIDTH-1:0]    pwm_out,
    output logic [NUM_CH-1:0]                   pwm_update,
    output logic                                led,
    output logic                                soft_rst,
    output logic                                cmd_err
);
    localparam int DUTY_W     = PWM_DATA_WIDTH - 2;
    localparam int DUTY_BYTES = (DUTY_W + 7) / 8;
    localparam int QD_BYTES   = (QD_DATA_WIDTH + 7) / 8;
    localparam int TX_W       = (QD_BYTES * 8 > 8) ? QD_BYTES * 8 : 8;
    localparam int CNT_W      = $clog2(TX_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_REPLY, S_DISCARD} state_t;

    logic [SYNC_STAGES-1:0]             r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                               r_sclk_d;
    state_t                             r_state;
    logic [2:0]                         r_bit_cnt;
    logic [6:0]                         r_shift;
    logic [7:0]                         r_byte_cnt;
    logic [3:0]                         r_ch;
    logic                               r_dir;
    logic [DUTY_W-1:0]                  r_duty;
    logic [TX_W-1:0]                    r_tx;
    logic [CNT_W-1:0]                   r_tx_cnt;
    logic                               r_status_rd;
    logic                               r_miso, r_led, r_soft_rst, r_cmd_err, r_abort;
    logic [NUM_CH*PWM_DATA_WIDTH-1:0]   r_pwm;
    logic [NUM_CH-1:0]                  r_pwm_update;

    logic                       w_sclk, w_cs_n, w_mosi, w_rise, w_fall, w_byte_done;
    logic [7:0]                 w_byte, w_status;
    logic                       w_ch_ok, w_cmd_ok;
    logic [DUTY_W-1:0]          w_duty_next;
    logic [PWM_DATA_WIDTH-1:0]  w_pwm_word;
    logic [QD_DATA_WIDTH-1:0]   w_qd_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk & ~r_sclk_d & ~w_cs_n;
    assign w_fall      = ~w_sclk & r_sclk_d & ~w_cs_n;
    assign w_byte      = {r_shift, w_mosi};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_status    = {r_cmd_err, r_abort, 6'(NUM_CH)};
    assign w_ch_ok     = {1'b0, w_byte[3:0]} < 5'(NUM_CH);
    assign w_cmd_ok    = ((w_byte[7:4] == 4'h1 || w_byte[7:4] == 4'h2) && w_ch_ok)
                         || w_byte == 8'h31 || w_byte == 8'h40 || w_byte == 8'hFF;
    assign w_duty_next = DUTY_W'({r_duty, w_byte});
    assign w_pwm_word  = {1'b0, r_dir, w_duty_next};

    always_comb begin
        w_qd_sel = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            if (w_byte[3:0] == 4'(c)) w_qd_sel = qd_count[c*QD_DATA_WIDTH +: QD_DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;  r_bit_cnt <= '0;  r_shift <= '0;  r_byte_cnt <= '0;
            r_ch <= '0;  r_dir <= 1'b0;  r_duty <= '0;  r_tx <= '0;  r_tx_cnt <= '0;
            r_status_rd <= 1'b0;  r_miso <= 1'b0;  r_led <= 1'b1;  r_soft_rst <= 1'b0;
            r_cmd_err <= 1'b0;  r_abort <= 1'b0;  r_pwm <= '0;  r_pwm_update <= '0;
        end else begin
            r_soft_rst   <= 1'b0;
            r_pwm_update <= '0;
            // Flag clears on the last status bit sit before any set below so a set wins.
            if (w_fall) begin
                if (r_state == S_REPLY && r_tx_cnt != '0) begin
                    r_miso   <= r_tx[TX_W-1];
                    r_tx     <= r_tx << 1;
                    r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    if (r_tx_cnt == CNT_W'(1) && r_status_rd) begin
                        r_cmd_err <= 1'b0;
                        r_abort   <= 1'b0;
                    end
                end else begin
                    r_miso <= 1'b0;
                end
            end
            if (w_rise) begin
                r_shift   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            case (r_state)
                S_IDLE: if (!w_cs_n) begin
                    r_state   <= S_CMD;
                    r_bit_cnt <= '0;
                end
                default: if (w_cs_n) begin
                    r_state    <= S_IDLE;
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_tx_cnt   <= '0;
                    r_miso     <= 1'b0;
                    // A frame already flagged as an error ends cleanly in DISCARD on a byte boundary.
                    if (!((r_state == S_CMD || r_state == S_DISCARD) && r_bit_cnt == '0))
                        r_abort <= 1'b1;
                end else if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            if (!w_cmd_ok) begin
                                r_cmd_err <= 1'b1;
                                r_state   <= S_DISCARD;
                            end else if (w_byte[7:4] == 4'h1) begin
                                r_ch       <= w_byte[3:0];
                                r_duty     <= '0;
                                r_byte_cnt <= 8'(1 + DUTY_BYTES);
                                r_state    <= S_ARG;
                            end else if (w_byte[7:4] == 4'h2) begin
                                r_tx        <= TX_W'(w_qd_sel);
                                r_tx_cnt    <= CNT_W'(QD_BYTES * 8);
                                r_byte_cnt  <= 8'(QD_BYTES);
                                r_status_rd <= 1'b0;
                                r_state     <= S_REPLY;
                            end else if (w_byte == 8'h40) begin
                                r_tx        <= TX_W'(w_status) << (TX_W - 8);
                                r_tx_cnt    <= CNT_W'(8);
                                r_byte_cnt  <= 8'd1;
                                r_status_rd <= 1'b1;
                                r_state     <= S_REPLY;
                            end else if (w_byte == 8'h31) begin
                                r_led <= ~r_led;
                            end else begin
                                r_soft_rst <= 1'b1;
                            end
                        end
                        S_ARG: begin
                            if (r_byte_cnt == 8'(1 + DUTY_BYTES)) r_dir  <= w_byte[0];
                            else                                  r_duty <= w_duty_next;
                            r_byte_cnt <= r_byte_cnt - 8'd1;
                            if (r_byte_cnt == 8'd1) begin
                                r_state <= S_CMD;
                                for (int unsigned c = 0; c < NUM_CH; c++)
                                    if (r_ch == 4'(c)) begin
                                        r_pwm[c*PWM_DATA_WIDTH +: PWM_DATA_WIDTH] <= w_pwm_word;
                                        r_pwm_update[c] <= 1'b1;
                                    end
                            end
                        end
                        S_REPLY: begin
                            r_byte_cnt <= r_byte_cnt - 8'd1;
                            if (r_byte_cnt == 8'd1) begin
                                r_state <= S_CMD;
                                r_miso  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign spi_miso   = r_miso;
    assign pwm_out    = r_pwm;
    assign pwm_update = r_pwm_update;
    assign led        = r_led;
    assign soft_rst   = r_soft_rst;
    assign cmd_err    = r_cmd_err;
endmodule

// File: tb/tb_spi_cmd_slave_mc.sv
// Scoreboard bench for spi_cmd_slave_mc: stimulus queues expected outputs, monitors pop and compare.
module tb_spi_cmd_slave_mc;
    localparam int NUM_CH = 2;
    localparam int PW     = 16;
    localparam int QW     = 16;
    localparam int HALF   = 8;   // clk cycles per SCLK half-period

    logic                   clk = 1'b0;
    logic                   rst, sclk, cs_n, mosi, miso;
    logic [NUM_CH*QW-1:0]   qd_count;
    logic [NUM_CH*PW-1:0]   pwm_out;
    logic [NUM_CH-1:0]      pwm_update;
    logic                   led, soft_rst, cmd_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic mon_en = 1'b0;
    logic prev_led;
    int   srst_w = 0;

    logic [7:0]  exp_miso_q[$];
    logic [1:0]  exp_upd_q[$];
    logic [31:0] exp_pwm_q[$];
    logic        exp_led_q[$];
    int          exp_srst_q[$];

    always #5 clk = ~clk;

    spi_cmd_slave_mc #(
        .NUM_CH(NUM_CH), .PWM_DATA_WIDTH(PW), .QD_DATA_WIDTH(QW), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso), .qd_count(qd_count), .pwm_out(pwm_out), .pwm_update(pwm_update),
        .led(led), .soft_rst(soft_rst), .cmd_err(cmd_err)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_extra(string name);
        n_checks++;
        $display("FAIL %s: got an unexpected output, expected none", name);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx);
        exp_miso_q.push_back(exp_rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_hi();
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // MISO sniffer: the master samples on each SCLK rise; partial bytes are dropped at CS high.
    initial begin : miso_mon
        int nb;
        logic [7:0] sh;
        nb = 0;
        sh = '0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) nb = 0;
            else begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_miso_q.size() == 0) fail_extra("miso_byte");
                    else check("miso_byte", sh, exp_miso_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (pwm_update != '0) begin
                if (exp_upd_q.size() == 0) fail_extra("pwm_update");
                else begin
                    check("pwm_update", pwm_update, exp_upd_q.pop_front());
                    check("pwm_out", pwm_out, exp_pwm_q.pop_front());
                end
            end
            if (led !== prev_led) begin
                if (exp_led_q.size() == 0) fail_extra("led");
                else check("led", led, exp_led_q.pop_front());
                prev_led = led;
            end
            if (soft_rst) srst_w++;
            else if (srst_w != 0) begin
                if (exp_srst_q.size() == 0) fail_extra("soft_rst");
                else check("soft_rst_width", srst_w, exp_srst_q.pop_front());
                srst_w = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; qd_count = '0;
        wait_clk(5);
        check("rst_miso", miso, 0);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_pwm_update", pwm_update, 0);
        check("rst_led", led, 1);
        check("rst_soft_rst", soft_rst, 0);
        check("rst_cmd_err", cmd_err, 0);
        rst = 1'b0;
        wait_clk(5);
        prev_led = led;
        mon_en = 1'b1;

        // SET_PWM channel 0, dir=1, duty 0x1234
        exp_upd_q.push_back(2'b01); exp_pwm_q.push_back(32'h0000_5234);
        cs_lo(); xfer(8'h10, 8'h00); xfer(8'h01, 8'h00); xfer(8'h12, 8'h00); xfer(8'h34, 8'h00); cs_hi();
        // SET_PWM channel 1, dir=0, duty 0xFFFF truncated to 14 bits
        exp_upd_q.push_back(2'b10); exp_pwm_q.push_back(32'h3FFF_5234);
        cs_lo(); xfer(8'h11, 8'h00); xfer(8'h00, 8'h00); xfer(8'hFF, 8'h00); xfer(8'hFF, 8'h00); cs_hi();

        // GET_COUNT ch1 with count changing mid-reply, then chained GET_COUNT ch0
        qd_count = {16'hBEEF, 16'h1357};
        cs_lo();
        xfer(8'h21, 8'h00);
        qd_count = {16'h0F0F, 16'hA5C3};
        xfer(8'h00, 8'hBE); xfer(8'h00, 8'hEF);
        xfer(8'h20, 8'h00); xfer(8'h00, 8'hA5); xfer(8'h00, 8'hC3);
        cs_hi();

        // Chaining: LED toggle, soft reset, LED toggle
        exp_led_q.push_back(1'b0); exp_led_q.push_back(1'b1); exp_srst_q.push_back(1);
        cs_lo(); xfer(8'h31, 8'h00); xfer(8'hFF, 8'h00); xfer(8'h31, 8'h00); cs_hi();
        check("led_after_chain", led, 1);

        // Bad channel: the rest of the frame is ignored
        cs_lo(); xfer(8'h13, 8'h00); xfer(8'h31, 8'h00); xfer(8'h10, 8'h00); xfer(8'h01, 8'h00); cs_hi();
        check("cmd_err_set", cmd_err, 1);
        cs_lo(); xfer(8'h40, 8'h00); xfer(8'h00, 8'h82); cs_hi();
        check("cmd_err_cleared", cmd_err, 0);

        // Abort inside SET_PWM arguments
        cs_lo(); xfer(8'h10, 8'h00); xfer(8'h01, 8'h00); cs_hi();
        check("pwm_after_abort", pwm_out, 32'h3FFF_5234);
        cs_lo(); xfer(8'h40, 8'h00); xfer(8'h00, 8'h42); cs_hi();
        cs_lo(); xfer(8'h40, 8'h00); xfer(8'h00, 8'h02); cs_hi();

        // Reset in the middle of a GET_COUNT reply byte
        qd_count = {16'hBEEF, 16'h1357};
        cs_lo();
        xfer(8'h21, 8'h00); xfer(8'h00, 8'hBE);
        for (int i = 0; i < 2; i++) begin
            mosi = 1'b0; wait_clk(HALF); sclk = 1'b1; wait_clk(HALF); sclk = 1'b0;
        end
        wait_clk(HALF);
        check("miso_before_rst", miso, 1);
        rst = 1'b1;
        wait_clk(3);
        check("rst_mid_miso", miso, 0);
        check("rst_mid_led", led, 1);
        check("rst_mid_pwm_out", pwm_out, 0);
        cs_n = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2 * HALF);

        cs_lo(); xfer(8'h40, 8'h00); xfer(8'h00, 8'h02); cs_hi();
        exp_upd_q.push_back(2'b01); exp_pwm_q.push_back(32'h0000_0005);
        cs_lo(); xfer(8'h10, 8'h00); xfer(8'h00, 8'h00); xfer(8'h00, 8'h00); xfer(8'h05, 8'h00); cs_hi();

        wait_clk(20);
        check("miso_q_left", exp_miso_q.size(), 0);
        check("pwm_q_left", exp_upd_q.size(), 0);
        check("led_q_left", exp_led_q.size(), 0);
        check("srst_q_left", exp_srst_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
